// File: rtl/foc_pkg.sv
// Shared fixed-point types, angle constants and saturation helper for the
// field-oriented-control datapath.
package foc_pkg;

    typedef logic signed [15:0] q15_t;

    localparam logic [15:0] ANG_PI      = 16'd32768;
    localparam logic [15:0] ANG_HALF_PI = 16'd16384;
    localparam int          K_INV_SQRT3 = 18919;

    // Clamp a wide signed intermediate into the Q1.15 range.
    function automatic q15_t sat16(input logic signed [33:0] x);
        if (x > 34'sd32767)
            return 16'sh7fff;
        else if (x < -34'sd32768)
            return 16'sh8000;
        else
            return x[15:0];
    endfunction

endpackage

// File: rtl/sine_lut.sv
// Quarter-wave sine table with one registered read; phase 0..65535 spans one
// full turn. Output is symmetric, so it never reaches -32768.
module sine_lut
    import foc_pkg::*;
#(
    parameter int LUT_AW = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] i_phase,
    output q15_t        o_sin
);

    localparam int  DEPTH   = 1 << LUT_AW;
    localparam real HALF_PI = 1.5707963267948966;

    logic [14:0]       w_tbl [DEPTH];
    logic [LUT_AW-1:0] w_idx;
    logic [LUT_AW-1:0] w_addr;
    logic              w_mirror;
    logic              w_top;
    logic              w_neg;
    logic [14:0]       w_mag;
    q15_t              r_sin;

    // Table contents are elaboration-time constants; entries are all non-negative.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tbl
            localparam int VAL = $rtoi(32767.0 * $sin(HALF_PI * gi / DEPTH) + 0.5);
            assign w_tbl[gi] = 15'(VAL);
        end
    endgenerate

    assign w_idx    = i_phase[13 -: LUT_AW];
    assign w_mirror = i_phase[14];
    assign w_neg    = (i_phase >= ANG_PI);

    // Descending quadrants read the table backwards; index 0 there is the peak,
    // which lies one step past the last stored entry.
    assign w_addr = w_mirror ? -w_idx : w_idx;
    assign w_top  = w_mirror && (w_idx == '0);
    assign w_mag  = w_top ? 15'h7fff : w_tbl[w_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_sin <= '0;
        else if (w_neg)
            r_sin <= -$signed({1'b0, w_mag});
        else
            r_sin <= $signed({1'b0, w_mag});
    end

    assign o_sin = r_sin;

endmodule

// File: rtl/clarke_park_xform.sv
// Four-stage Clarke (ia, ib -> alpha, beta) and Park (alpha, beta, phi -> id, iq)
// transform, one sample per clock, no back-pressure.
module clarke_park_xform
    import foc_pkg::*;
#(
    parameter int LUT_AW      = 8,
    parameter int K_INV_SQRT3 = foc_pkg::K_INV_SQRT3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_valid,
    input  logic signed [15:0] ia,
    input  logic signed [15:0] ib,
    input  logic        [15:0] phi,
    output logic               o_valid,
    output logic signed [15:0] alpha,
    output logic signed [15:0] beta,
    output logic signed [15:0] id,
    output logic signed [15:0] iq
);

    localparam logic signed [33:0] K_Q15 = 34'(K_INV_SQRT3);

    logic signed [17:0] w_s;
    logic        [15:0] w_cos_phase;
    logic signed [33:0] w_beta_prod;
    q15_t               w_sin;
    q15_t               w_cos;
    logic signed [32:0] w_id_sum;
    logic signed [32:0] w_iq_sum;

    logic               r1_valid;
    q15_t               r1_ia;
    logic signed [17:0] r1_s;
    logic        [15:0] r1_phi;

    logic               r2_valid;
    q15_t               r2_alpha;
    q15_t               r2_beta;

    logic               r3_valid;
    q15_t               r3_alpha;
    q15_t               r3_beta;
    logic signed [31:0] r3_ac;
    logic signed [31:0] r3_bs;
    logic signed [31:0] r3_as;
    logic signed [31:0] r3_bc;

    assign w_s         = $signed({{2{ia[15]}}, ia}) + $signed({ib[15], ib, 1'b0});
    assign w_cos_phase = r1_phi + ANG_HALF_PI;
    assign w_beta_prod = $signed({{16{r1_s[17]}}, r1_s}) * K_Q15;

    sine_lut #(.LUT_AW(LUT_AW)) u_sin (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_phase (r1_phi),
        .o_sin   (w_sin)
    );

    sine_lut #(.LUT_AW(LUT_AW)) u_cos (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_phase (w_cos_phase),
        .o_sin   (w_cos)
    );

    assign w_id_sum = $signed({r3_ac[31], r3_ac}) + $signed({r3_bs[31], r3_bs});
    assign w_iq_sum = $signed({r3_bc[31], r3_bc}) - $signed({r3_as[31], r3_as});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_valid <= 1'b0;
            r1_ia    <= '0;
            r1_s     <= '0;
            r1_phi   <= '0;
            r2_valid <= 1'b0;
            r2_alpha <= '0;
            r2_beta  <= '0;
            r3_valid <= 1'b0;
            r3_alpha <= '0;
            r3_beta  <= '0;
            r3_ac    <= '0;
            r3_bs    <= '0;
            r3_as    <= '0;
            r3_bc    <= '0;
            o_valid  <= 1'b0;
            alpha    <= '0;
            beta     <= '0;
            id       <= '0;
            iq       <= '0;
        end else begin
            r1_valid <= i_valid;
            r1_ia    <= ia;
            r1_s     <= w_s;
            r1_phi   <= phi;

            // Sine/cosine registers inside the LUTs line up with this stage.
            r2_valid <= r1_valid;
            r2_alpha <= r1_ia;
            r2_beta  <= sat16(w_beta_prod >>> 15);

            r3_valid <= r2_valid;
            r3_alpha <= r2_alpha;
            r3_beta  <= r2_beta;
            r3_ac    <= r2_alpha * w_cos;
            r3_bs    <= r2_beta * w_sin;
            r3_as    <= r2_alpha * w_sin;
            r3_bc    <= r2_beta * w_cos;

            o_valid <= r3_valid;
            if (r3_valid) begin
                alpha <= r3_alpha;
                beta  <= r3_beta;
                id    <= sat16($signed({w_id_sum[32], w_id_sum}) >>> 15);
                iq    <= sat16($signed({w_iq_sum[32], w_iq_sum}) >>> 15);
            end
        end
    end

endmodule

// File: tb/tb_clarke_park_xform.sv
// Scoreboard bench for clarke_park_xform: stimulus pushes expected results,
// a negedge monitor pops and compares whenever o_valid is seen.
module tb_clarke_park_xform;

    localparam real PI  = 3.14159265358979;
    localparam real AMP = 16000.0;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               i_valid;
    logic signed [15:0] ia;
    logic signed [15:0] ib;
    logic        [15:0] phi;
    logic               o_valid;
    logic signed [15:0] alpha;
    logic signed [15:0] beta;
    logic signed [15:0] id;
    logic signed [15:0] iq;

    typedef struct {
        int alpha;
        int beta;
        int id;
        int iq;
        int tol;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;
    int   checks = 0;
    int   errors = 0;
    int   n_out  = 0;

    always #5 clk = ~clk;

    clarke_park_xform dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (i_valid),
        .ia      (ia),
        .ib      (ib),
        .phi     (phi),
        .o_valid (o_valid),
        .alpha   (alpha),
        .beta    (beta),
        .id      (id),
        .iq      (iq)
    );

    function automatic void chk(input string name, input int act, input int req, input int tol);
        checks++;
        if (act > req + tol || act < req - tol) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, req, tol);
        end
    endfunction

    // Monitor: reset clears everything, valid outputs match the oldest expectation,
    // idle cycles hold the last exact result.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst_n) begin
            chk("rst_o_valid", int'(o_valid), 0, 0);
            chk("rst_alpha", int'(alpha), 0, 0);
            chk("rst_beta", int'(beta), 0, 0);
            chk("rst_id", int'(id), 0, 0);
            chk("rst_iq", int'(iq), 0, 0);
            last_exp = '{0, 0, 0, 0, 0};
        end else if (o_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: o_valid=1 alpha=%0d, expected no sample in flight", alpha);
            end else begin
                e = sb.pop_front();
                n_out++;
                $display("out %0d: alpha=%0d beta=%0d id=%0d iq=%0d (exp %0d %0d %0d %0d tol %0d)",
                         n_out, alpha, beta, id, iq, e.alpha, e.beta, e.id, e.iq, e.tol);
                chk("alpha", int'(alpha), e.alpha, 0);
                chk("beta", int'(beta), e.beta, e.tol);
                chk("id", int'(id), e.id, e.tol);
                chk("iq", int'(iq), e.iq, e.tol);
                last_exp = e;
            end
        end else if (last_exp.tol == 0) begin
            chk("hold_alpha", int'(alpha), last_exp.alpha, 0);
            chk("hold_id", int'(id), last_exp.id, 0);
            chk("hold_iq", int'(iq), last_exp.iq, 0);
        end
    end

    task automatic drive(input bit v, input int a, input int b, input int p,
                         input int ea, input int eb, input int eid, input int eiq, input int tol);
        exp_t e;
        @(posedge clk);
        #1;
        i_valid = v;
        ia      = 16'(a);
        ib      = 16'(b);
        phi     = 16'(p);
        if (v) begin
            e = '{ea, eb, eid, eiq, tol};
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            drive(1'b0, int'($urandom), int'($urandom), int'($urandom), 0, 0, 0, 0, 0);
    endtask

    // Hold reset with random traffic on the inputs; anything in flight is dropped.
    task automatic reset_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            rst_n   = 1'b0;
            sb.delete();
            i_valid = 1'($urandom);
            ia      = 16'($urandom);
            ib      = 16'($urandom);
            phi     = 16'($urandom);
        end
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        i_valid = 1'b0;
    endtask

    initial begin : stim
        rst_n   = 1'b1;
        i_valid = 1'b0;
        ia      = '0;
        ib      = '0;
        phi     = '0;
        #1;
        rst_n = 1'b0;
        reset_cycles(5);
        idle(3);

        // Single pulse: o_valid must rise on exactly the fourth clock after sampling.
        drive(1'b1, 1000, -500, 0, 1000, 0, 999, 0, 0);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            i_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("latency_clk%0d", k), int'(o_valid), int'(k == 4), 0);
        end

        // Directed vectors; truncation toward -inf makes 1000*32767>>>15 come out as 999.
        drive(1'b1, 1000, -500, 16384, 1000, 0, 0, -1000, 0);
        drive(1'b1, 0, 1000, 0, 0, 1154, 0, 1153, 0);
        drive(1'b0, 123, 456, 789, 0, 0, 0, 0, 0);
        drive(1'b1, 32767, 32767, 0, 32767, 32767, 32766, 32766, 0);
        drive(1'b1, -32768, -32768, 8192, -32768, -32768, -32768, 0, 0);
        drive(1'b0, 1, 2, 3, 0, 0, 0, 0, 0);
        drive(1'b1, 32767, 32767, 8192, 32767, 32767, 32767, 0, 0);
        drive(1'b1, 1000, -500, 32768, 1000, 0, -1000, 0, 0);
        drive(1'b1, 1000, -500, 49152, 1000, 0, 0, 999, 0);
        drive(1'b0, 9, 9, 9, 0, 0, 0, 0, 0);
        drive(1'b1, 1000, -500, 63, 1000, 0, 999, 0, 0);
        drive(1'b1, 0, -1000, 0, 0, -1155, 0, -1155, 0);
        drive(1'b1, 1000, -500, 65535, 1000, 0, 999, 6, 0);
        idle(6);

        // Rotating balanced currents swept across the 65535 -> 0 wrap. The LUT
        // drops the low 6 phase bits, so the rotor frame lags by (theta mod 64).
        for (int k = 0; k < 40; k++) begin
            int  th;
            int  a;
            int  b;
            real tr;
            real d;
            th = (65336 + 10 * k) % 65536;
            tr = 2.0 * PI * th / 65536.0;
            d  = 2.0 * PI * (th % 64) / 65536.0;
            a  = int'(AMP * $cos(tr));
            b  = int'(AMP * $cos(tr - 2.0 * PI / 3.0));
            drive(1'b1, a, b, th, a, int'(AMP * $sin(tr)), int'(AMP * $cos(d)), int'(AMP * $sin(d)), 80);
        end
        idle(6);
        chk("drain_after_sweep", sb.size(), 0, 0);

        // Back-to-back traffic cut off by reset: only samples already out are checked.
        drive(1'b1, 1000, -500, 0, 1000, 0, 999, 0, 0);
        drive(1'b1, 0, 1000, 0, 0, 1154, 0, 1153, 0);
        drive(1'b1, 1000, -500, 16384, 1000, 0, 0, -1000, 0);
        drive(1'b1, 32767, 32767, 8192, 32767, 32767, 32767, 0, 0);
        drive(1'b1, 0, -1000, 0, 0, -1155, 0, -1155, 0);
        reset_cycles(2);
        idle(8);
        drive(1'b1, 1000, -500, 49152, 1000, 0, 0, 999, 0);
        idle(6);
        chk("drain_after_reset", sb.size(), 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time exceeded, expected completion before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
